serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial adder sequencer that computes a WIDTH-bit sum with one shared `full_adder_1bit` instance, one bit per clock, LSB first. The block latches operands on a start request, steps the 1-bit adder WIDTH times through a registered carry, and presents the registered result with a one-cycle done pulse. It is the area-minimal alternative to a ripple-carry array in the arithmetic library, trading latency for a single adder cell.

## Interface

- `WIDTH`, default 8: operand and sum width in bits; legal range is WIDTH >= 2.

- `clk  input  1`: single clock; all state updates on its rising edge.
- `rst  input  1`: reset, synchronous and active-high.
- `start  input  1`: request a new addition; sampled only in IDLE.
- `a  input  WIDTH`: operand A; sampled on the accepting edge only.
- `b  input  WIDTH`: operand B; sampled on the accepting edge only.
- `cin  input  1`: carry-in; sampled on the accepting edge only.
- `busy  output  1`: high whenever the state is not IDLE.
- `done  output  1`: one-cycle pulse while in DONE; `sum` and `cout` are valid.
- `sum  output  WIDTH`: registered result of a + b + cin (low WIDTH bits).
- `cout  output  1`: registered carry-out of the final bit.

## Operation

- Datapath:
  - Operand shift registers A_sh and B_sh, each WIDTH bits, shift right.
  - Carry flip-flop c_q.
  - Partial-sum shift register S_sh, WIDTH bits, filled from the MSB and shifting right.
  - Bit counter, $clog2(WIDTH+1) bits.
  - One `full_adder_1bit` with inputs (A_sh[0], B_sh[0], c_q).
- States are IDLE, RUN and DONE.
- IDLE:
  - `busy`=0 and `done`=0.
  - If `start`=1 at an edge: A_sh<=a, B_sh<=b, c_q<=cin, counter<=0, then go to RUN.
  - Otherwise stay in IDLE.
- RUN, once per cycle:
  - S_sh <= {fa_sum, S_sh[WIDTH-1:1]} and c_q <= fa_cout.
  - A_sh and B_sh shift right by one.
  - counter increments.
  - On the edge where counter == WIDTH-1: `sum` <= {fa_sum, S_sh[WIDTH-1:1]}, `cout` <= fa_cout, then go to DONE.
- DONE: `done`=1 for exactly this cycle, then unconditionally go to IDLE.
- `sum` and `cout` change only on the edge entering DONE. They hold that value through later operations until the next completion.
- `start` is ignored in RUN and in DONE, with no queuing.
- `a`, `b` and `cin` changes after the accepting edge do not affect the result in flight.
- Arithmetic: {cout,sum} == a + b + cin, exact over all 2^(2·WIDTH+1) input combinations. Overflow appears only in `cout`.

## Timing

- Reset values, applied on the first rising edge with `rst`=1:
  - state=IDLE; `busy`=0, `done`=0.
  - `sum`=0, `cout`=0.
  - all internal registers 0.
- Reset has priority over all other activity.
- Reset mid-RUN or in DONE: the operation is aborted, no `done` pulse is produced, and `sum`/`cout` are cleared to 0.
- Latency, with `start` accepted at edge E0:
  - `busy`=1 from E0 up to edge E0+WIDTH+1.
  - RUN occupies edges E0+1 through E0+WIDTH.
  - `sum`/`cout` update at E0+WIDTH.
  - `done`=1 in the cycle between E0+WIDTH and E0+WIDTH+1.
  - `busy`=0 after E0+WIDTH+1.
- Throughput: with `start` held high, one operation every WIDTH+2 cycles. The next accept is at E0+WIDTH+2, the first IDLE edge.
- `done` and `busy` are registered state decodes with no combinational path from inputs.
- The `full_adder_1bit` path is purely combinational between registers, so the critical path is one full-adder delay.

## Test plan

All scenarios use WIDTH=8.

1. Reset: hold `rst`=1 for 2 cycles with random inputs -> `busy`=0, `done`=0, `sum`=8'h00, `cout`=0; `start`=1 during reset causes no operation.
2. Basic add: a=8'h5A, b=8'h3C, cin=0, `start` pulsed 1 cycle -> `done` high exactly 8 edges after the accept, with `sum`=8'h96 and `cout`=0; `busy` high for 9 cycles.
3. Carry corner cases:
   - a=8'hFF, b=8'h01, cin=0 -> `sum`=8'h00, `cout`=1.
   - a=8'hFF, b=8'hFF, cin=1 -> `sum`=8'hFF, `cout`=1.
   - a=0, b=0, cin=1 -> `sum`=8'h01, `cout`=0.
4. Input isolation:
   - Start a=8'h10, b=8'h20, cin=0.
   - At RUN cycle 3, pulse `start` and change a=8'hFF, b=8'hFF, cin=1.
   - Required: result `sum`=8'h30, `cout`=0; exactly one `done` pulse; no second operation launched.
5. Reset mid-operation:
   - Start a=8'h5A, b=8'h3C, cin=0 after a prior completion left `sum`=8'h96.
   - Assert `rst` at RUN cycle 4.
   - Required: `busy`=0, `sum`=0, `cout`=0, no `done` pulse.
   - A new start with a=8'h01, b=8'h02, cin=0 then gives `sum`=8'h03, `cout`=0.
6. Back-to-back and exhaustive:
   - With `start` held high, `done` pulses every 10 cycles and `sum` holds its value between pulses.
   - A randomized 1000-operation run matches the reference model {cout,sum}=a+b+cin.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell stepped WIDTH times, LSB first,
// with a registered carry. Operands latch on start; the result is registered
// and presented alongside a one-cycle done pulse.

module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic fa_sum, fa_cout;

  // The single shared adder cell sees the current LSBs and the carry flop.
  full_adder_1bit u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (c_q),
    .s  (fa_sum),
    .co (fa_cout)
  );

  // Next-state and datapath updates; everything holds unless a state acts on it.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          c_d     = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_sh_d = {fa_sum, s_sh_q[WIDTH-1:1]};
        c_d    = fa_cout;
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        // Last bit: publish the assembled word straight from the shift input.
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = {fa_sum, s_sh_q[WIDTH-1:1]};
          cout_d  = fa_cout;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl at WIDTH=8: directed table, corner sequences,
// back-to-back throughput and a randomized run against a+b+cin arithmetic.

module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout;

  int n_cmp = 0;
  int n_err = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Launch one operation from IDLE and watch WIDTH+3 cycles. Operands are
  // scrambled right after acceptance; inj>0 pulses start with all-ones
  // operands in that post-accept cycle to show it is ignored.
  task automatic do_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tc, input logic [W-1:0] es, input logic ec, input int inj);
    int bcnt = 0, dcnt = 0, lat = -1;
    logic [W-1:0] ds = '0;
    logic dc = 1'b0;
    @(negedge clk);
    start = 1'b1; a = ta; b = tb; cin = tc;
    @(posedge clk);                     // accepting edge E0
    for (int k = 1; k <= W + 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end
      if (inj > 0 && k == inj) begin
        start = 1'b1; a = '1; b = '1; cin = 1'b1;
      end
      if (inj > 0 && k == inj + 1) start = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        if (lat < 0) begin lat = k - 1; ds = sum; dc = cout; end
        dcnt++;
      end
    end
    chk({nm, "_lat"},   32'(lat),  32'(W));
    chk({nm, "_ndone"}, 32'(dcnt), 32'd1);
    chk({nm, "_busy"},  32'(bcnt), 32'(W + 1));
    chk({nm, "_sum"},   32'(ds),   32'(es));
    chk({nm, "_cout"},  32'(dc),   32'(ec));
    chk({nm, "_hold"},  32'({cout, sum}), 32'({ec, es}));
  endtask

  initial begin
    logic [W:0] ref_r;
    int dcyc[$];
    logic [W-1:0] prev_s;
    int nd;

    tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};

    // Reset with start asserted and random operands.
    rst = 1'b1; start = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(sum),  32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Directed table.
    foreach (tbl[i])
      do_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].co, 0);

    // Input isolation: start pulse plus operand change at RUN cycle 3.
    do_op("iso", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 3);

    // Reset mid-operation after a completion left 0x96.
    do_op("pre_rst", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0);
    @(negedge clk);
    start = 1'b1; a = 8'h5A; b = 8'h3C; cin = 1'b0;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_sum",  32'(sum),  32'd0);
    chk("mid_rst_cout", 32'(cout), 32'd0);
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("mid_rst_nodone", 32'(nd), 32'd0);
    do_op("after_rst", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 0);

    // Back-to-back with start held high: period WIDTH+2, sum stable between pulses.
    @(negedge clk);
    start = 1'b1; a = 8'hC3; b = 8'h7E; cin = 1'b1;   // 0xC3+0x7E+1 = 0x142
    prev_s = sum;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (done) begin
        dcyc.push_back(k);
        chk("b2b_sum",  32'(sum),  32'h42);
        chk("b2b_cout", 32'(cout), 32'd1);
      end else if (dcyc.size() > 0) begin
        chk("b2b_hold", 32'(sum), 32'(prev_s));
      end
      prev_s = sum;
    end
    start = 1'b0;
    chk("b2b_count", 32'(dcyc.size()), 32'd4);
    for (int i = 1; i < dcyc.size(); i++)
      chk("b2b_period", 32'(dcyc[i] - dcyc[i-1]), 32'(W + 2));
    repeat (W + 3) @(negedge clk);

    // Randomized run against plain arithmetic.
    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] ra, rb;
      logic rc;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      ref_r = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      do_op("rnd", ra, rb, rc, ref_r[W-1:0], ref_r[W], 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
